td4_run_ctrl: RTL and testbench

Execution controller for the 4-bit TD4 CPU on ULX3S.
- Generates a single-cycle clock enable `cpu_ce` and a CPU reset `cpu_n_reset`, so the CPU advances in RUN, STEP or HALT mode at a selectable rate.
- Watches the fetch bus (`address` and `dout`) and auto-halts on a jump-to-self (the end-of-program idle loop) or on an address breakpoint.
- Sits between the board buttons/switches and the cpu + program ROM pair.

---
 rtl/td4_pkg.sv | 21 ++
 rtl/td4_rate_div.sv | 62 ++++++
 rtl/td4_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_td4_run_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// -----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 execution controller.
//   mode_t     : controller states; the encoding is visible on the `mode` port
//                (0 RST_HOLD, 1 HALT, 2 RUN, 3 STEP).
//   OP_JMP     : upper opcode nibble of the TD4 immediate jump instruction.
//   DIV_W_DEF  : default width of the rate divider counter.
// -----------------------------------------------------------------------------
package td4_pkg;

   typedef enum logic [1:0] {
      MODE_RST_HOLD = 2'd0,
      MODE_HALT     = 2'd1,
      MODE_RUN      = 2'd2,
      MODE_STEP     = 2'd3
   } mode_t;

   localparam logic [3:0] OP_JMP    = 4'b1111;
   localparam int         DIV_W_DEF = 24;

endpackage : td4_pkg

// File: rtl/td4_rate_div.sv
// -----------------------------------------------------------------------------
// td4_rate_div
// Free-running rate divider for RUN mode. Counts 0..P-1 and flags `tick` in
// the cycle where the count equals P-1. The period P is picked from
// `rate_sel` only while the count is 0, so a change in mid-period takes
// effect at the start of the next period. rate_sel=0 means P=1 (tick every
// cycle).
// Ports:
//   clk       in   system clock
//   n_reset   in   synchronous active-low reset
//   clr       in   synchronous clear (holds the counter at 0)
//   rate_sel  in   period select: 0 -> 1, 1 -> DIV1, 2 -> DIV2, 3 -> DIV3
//   tick      out  combinational, high in the last cycle of a period
// -----------------------------------------------------------------------------
module td4_rate_div
   import td4_pkg::*;
#(
   parameter int               DIV_W = DIV_W_DEF,
   parameter logic [DIV_W-1:0] DIV1  = DIV_W'(2),
   parameter logic [DIV_W-1:0] DIV2  = DIV_W'(2_500_000),
   parameter logic [DIV_W-1:0] DIV3  = DIV_W'(12_500_000)
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       clr,
   input  logic [1:0] rate_sel,
   output logic       tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] per_q;
   logic [DIV_W-1:0] per_sel;
   logic [DIV_W-1:0] per_eff;

   always_comb begin
      unique case (rate_sel)
         2'd0:    per_sel = DIV_W'(1);
         2'd1:    per_sel = DIV1;
         2'd2:    per_sel = DIV2;
         default: per_sel = DIV3;
      endcase
   end

   // At count 0 a new period starts, so the live selection is used; otherwise
   // the period latched at the start of this one stays in force.
   assign per_eff = (cnt == '0) ? per_sel : per_q;
   assign tick    = (cnt == per_eff - 1'b1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!n_reset || clr) begin
         cnt   <= '0;
         per_q <= DIV_W'(1);
      end else begin
         if (cnt == '0)
            per_q <= per_sel;
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule : td4_rate_div

// File: rtl/td4_run_ctrl.sv
// -----------------------------------------------------------------------------
// td4_run_ctrl
// Execution controller for the TD4 CPU. Turns button edges into RUN / STEP /
// HALT / CPU-reset sequencing, produces a one-cycle CPU clock enable at the
// selected rate, and auto-halts on a jump-to-self (end-of-program idle loop)
// or, when built with TD4_BREAKPOINT_EN defined, on an address breakpoint.
// Without TD4_BREAKPOINT_EN, bp_en/bp_addr are ignored and bp_hit stays 0.
// Ports:
//   clk          in   system clock
//   n_reset      in   synchronous active-low reset of this block
//   btn_reset    in   CPU reset request (rising edge)
//   btn_run      in   RUN request (rising edge)
//   btn_step     in   single-step request (rising edge)
//   btn_halt     in   HALT request (rising edge)
//   rate_sel     in   RUN rate select (see td4_rate_div)
//   address      in   CPU program counter
//   dout         in   instruction currently fetched from ROM
//   bp_en        in   breakpoint enable
//   bp_addr      in   breakpoint address
//   cpu_ce       out  one-cycle CPU advance enable (registered)
//   cpu_n_reset  out  active-low CPU reset (registered)
//   mode         out  current state, mode_t encoding
//   loop_halt    out  sticky: halted on jump-to-self
//   bp_hit       out  sticky: halted on breakpoint
// -----------------------------------------------------------------------------
module td4_run_ctrl
   import td4_pkg::*;
#(
   parameter int               DIV_W   = DIV_W_DEF,
   parameter logic [DIV_W-1:0] DIV1    = DIV_W'(2),
   parameter logic [DIV_W-1:0] DIV2    = DIV_W'(2_500_000),
   parameter logic [DIV_W-1:0] DIV3    = DIV_W'(12_500_000),
   parameter int               RST_CYC = 4
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       btn_reset,
   input  logic       btn_run,
   input  logic       btn_step,
   input  logic       btn_halt,
   input  logic [1:0] rate_sel,
   input  logic [3:0] address,
   input  logic [7:0] dout,
   input  logic       bp_en,
   input  logic [3:0] bp_addr,
   output logic       cpu_ce,
   output logic       cpu_n_reset,
   output logic [1:0] mode,
   output logic       loop_halt,
   output logic       bp_hit
);

   localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

   mode_t         state_q, state_d;
   logic [RW-1:0] rst_cnt, rst_cnt_d;
   logic          armed, armed_d;
   logic          ce_d, loop_d, bp_d;

   logic reset_q, run_q, step_q, halt_q;
   logic reset_rise, run_rise, step_rise, halt_rise;
   logic tick, div_clr, bp_match;

   assign reset_rise = btn_reset & ~reset_q;
   assign run_rise   = btn_run   & ~run_q;
   assign step_rise  = btn_step  & ~step_q;
   assign halt_rise  = btn_halt  & ~halt_q;

   // The divider only runs in RUN; any other state holds it at 0, so entering
   // RUN always starts a fresh period.
   assign div_clr = (state_q != MODE_RUN);

   td4_rate_div #(
      .DIV_W (DIV_W),
      .DIV1  (DIV1),
      .DIV2  (DIV2),
      .DIV3  (DIV3)
   ) u_rate_div (
      .clk      (clk),
      .n_reset  (n_reset),
      .clr      (div_clr),
      .rate_sel (rate_sel),
      .tick     (tick)
   );

`ifdef TD4_BREAKPOINT_EN
   // `armed` is low until the first instruction after leaving HALT has been
   // issued, so resuming from a breakpoint steps past it.
   assign bp_match = bp_en && (address == bp_addr) && armed;
`else
   logic unused_bp;
   assign bp_match  = 1'b0;
   assign unused_bp = ^{bp_en, bp_addr, armed};
`endif

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt;
      armed_d   = armed;
      loop_d    = loop_halt;
      bp_d      = bp_hit;
      ce_d      = 1'b0;

      if (reset_rise) begin
         state_d   = MODE_RST_HOLD;
         rst_cnt_d = '0;
         loop_d    = 1'b0;
         bp_d      = 1'b0;
      end else begin
         unique case (state_q)
            MODE_RST_HOLD: begin
               if (rst_cnt == RST_LAST)
                  state_d = MODE_HALT;
               else
                  rst_cnt_d = rst_cnt + 1'b1;
            end
            MODE_HALT: begin
               // halt outranks run and step when they rise together
               if (halt_rise) begin
                  state_d = MODE_HALT;
               end else if (run_rise) begin
                  state_d = MODE_RUN;
                  loop_d  = 1'b0;
                  bp_d    = 1'b0;
                  armed_d = 1'b0;
               end else if (step_rise) begin
                  state_d = MODE_STEP;
               end
            end
            MODE_RUN: begin
               if (halt_rise) begin
                  state_d = MODE_HALT;
               end else if (tick) begin
                  if (dout == {OP_JMP, address}) begin
                     loop_d  = 1'b1;
                     state_d = MODE_HALT;
                  end else if (bp_match) begin
                     bp_d    = 1'b1;
                     state_d = MODE_HALT;
                  end else begin
                     ce_d    = 1'b1;
                     armed_d = 1'b1;
                  end
               end
            end
            default: begin // MODE_STEP: unconditional single advance
               ce_d    = 1'b1;
               state_d = MODE_HALT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q     <= MODE_RST_HOLD;
         rst_cnt     <= '0;
         armed       <= 1'b0;
         cpu_ce      <= 1'b0;
         cpu_n_reset <= 1'b0;
         loop_halt   <= 1'b0;
         bp_hit      <= 1'b0;
         reset_q     <= 1'b0;
         run_q       <= 1'b0;
         step_q      <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt     <= rst_cnt_d;
         armed       <= armed_d;
         cpu_ce      <= ce_d;
         cpu_n_reset <= (state_d != MODE_RST_HOLD);
         loop_halt   <= loop_d;
         bp_hit      <= bp_d;
         reset_q     <= btn_reset;
         run_q       <= btn_run;
         step_q      <= btn_step;
         halt_q      <= btn_halt;
      end
   end

   assign mode = state_q;

endmodule : td4_run_ctrl

// File: tb/tb_td4_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_td4_run_ctrl
// Self-checking bench for td4_run_ctrl: a table of hand-derived vectors from
// reset through STEP, RUN, jump-to-self, HALT and CPU reset; hand sequences
// for the breakpoint and step-idle cases; then randomized stimulus compared
// cycle by cycle against a behavioural model of the controller rules.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_td4_run_ctrl;

   localparam int RST_CYC = 4;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       btn_reset, btn_run, btn_step, btn_halt;
   logic [1:0] rate_sel;
   logic [3:0] address;
   logic [7:0] dout;
   logic       bp_en;
   logic [3:0] bp_addr;
   logic       cpu_ce, cpu_n_reset, loop_halt, bp_hit;
   logic [1:0] mode;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   td4_run_ctrl #(.RST_CYC(RST_CYC)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .btn_reset   (btn_reset),
      .btn_run     (btn_run),
      .btn_step    (btn_step),
      .btn_halt    (btn_halt),
      .rate_sel    (rate_sel),
      .address     (address),
      .dout        (dout),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .cpu_ce      (cpu_ce),
      .cpu_n_reset (cpu_n_reset),
      .mode        (mode),
      .loop_halt   (loop_halt),
      .bp_hit      (bp_hit)
   );

   // ---------------- behavioural reference model ----------------
   // Mode numbers: 0 reset hold, 1 halt, 2 run, 3 step.
   int   m_mode, m_hold_left, m_phase, m_period;
   bit   m_ce, m_nrst, m_loop, m_bp, m_armed;
   bit   p_reset, p_run, p_step, p_halt;

   function automatic int period_of(input logic [1:0] r);
      case (r)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 2_500_000;
         default: return 12_500_000;
      endcase
   endfunction

   task automatic model_step();
      bit r_rst, r_run, r_step, r_halt, tick, bp_ok;
      m_ce = 0;
      if (!n_reset) begin
         m_mode = 0; m_hold_left = RST_CYC; m_nrst = 0;
         m_loop = 0; m_bp = 0; m_armed = 0; m_phase = 0;
         {p_reset, p_run, p_step, p_halt} = 4'b0;
         return;
      end
      r_rst  = btn_reset && !p_reset;
      r_run  = btn_run   && !p_run;
      r_step = btn_step  && !p_step;
      r_halt = btn_halt  && !p_halt;
      {p_reset, p_run, p_step, p_halt} = {btn_reset, btn_run, btn_step, btn_halt};
      if (r_rst) begin
         m_mode = 0; m_hold_left = RST_CYC; m_loop = 0; m_bp = 0;
      end else if (m_mode == 0) begin
         m_hold_left--;
         if (m_hold_left == 0) m_mode = 1;
      end else if (m_mode == 1) begin
         if (r_halt) m_mode = 1;
         else if (r_run) begin
            m_mode = 2; m_phase = 0; m_loop = 0; m_bp = 0; m_armed = 0;
         end else if (r_step) m_mode = 3;
      end else if (m_mode == 3) begin
         m_ce = 1; m_mode = 1;
      end else begin
         if (m_phase == 0) m_period = period_of(rate_sel);
         tick = (m_phase + 1 == m_period);
         m_phase = tick ? 0 : m_phase + 1;
         bp_ok = 0;
`ifdef TD4_BREAKPOINT_EN
         bp_ok = bp_en && (address == bp_addr) && m_armed;
`endif
         if (r_halt) m_mode = 1;
         else if (tick) begin
            if (dout[7:4] == 4'hF && dout[3:0] == address) begin
               m_loop = 1; m_mode = 1;
            end else if (bp_ok) begin
               m_bp = 1; m_mode = 1;
            end else begin
               m_ce = 1; m_armed = 1;
            end
         end
      end
      m_nrst = (m_mode != 0);
   endtask

   // ---------------- helpers ----------------
   function automatic logic [5:0] dut_out();
      return {cpu_ce, cpu_n_reset, mode, loop_halt, bp_hit};
   endfunction

   function automatic logic [5:0] model_out();
      logic [1:0] mm;
      mm = 2'(m_mode);
      return {m_ce, m_nrst, mm, m_loop, m_bp};
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got {ce,nrst,mode,loop,bp}=%b, expected %b", name, $time, act, exp);
      end
   endtask

   // One clock: the model consumes the inputs visible at the edge, then the
   // DUT outputs are sampled 1 ns later.
   task automatic apply();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic rn, input logic [3:0] b, input logic [1:0] r,
                         input logic [3:0] a, input logic [7:0] d);
      n_reset = rn;
      {btn_reset, btn_halt, btn_run, btn_step} = b;
      rate_sel = r; address = a; dout = d;
   endtask

   // ---------------- vector table ----------------
   // btn field is {reset, halt, run, step}; exp is {ce, nrst, mode, loop, bp}.
   typedef struct {
      logic       rn;
      logic [3:0] btn;
      logic [1:0] rate;
      logic [3:0] addr;
      logic [7:0] dout;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic rn, input logic [3:0] b, input logic [1:0] r,
                              input logic [3:0] a, input logic [7:0] d,
                              input logic ce, input logic nr, input logic [1:0] m,
                              input logic lp);
      vec_t t;
      t.rn = rn; t.btn = b; t.rate = r; t.addr = a; t.dout = d;
      t.exp = {ce, nr, m, lp, 1'b0};
      return t;
   endfunction

   initial begin
      logic [5:0] exp_v;
      bp_en = 1'b0; bp_addr = 4'h0;
      set_in(1'b0, 4'b0000, 2'd0, 4'h0, 8'h01);

      // reset sequence
      tbl.push_back(v(0, 4'b0000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(0, 4'b0000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 1, 1, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 1, 1, 0));
      // single step at address 3
      tbl.push_back(v(1, 4'b0001, 0, 4'h3, 8'h01, 0, 1, 3, 0));
      tbl.push_back(v(1, 4'b0001, 0, 4'h3, 8'h01, 1, 1, 1, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h3, 8'h01, 0, 1, 1, 0));
      // RUN at P=2, then switch to P=1 mid-period
      tbl.push_back(v(1, 4'b0010, 1, 4'h0, 8'h01, 0, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 1, 4'h0, 8'h01, 0, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 1, 4'h0, 8'h01, 1, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 1, 4'h0, 8'h01, 0, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 1, 4'h0, 8'h01, 1, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 1, 4'h0, 8'h01, 0, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 1, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 1, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 1, 1, 2, 0));
      // jump-to-self auto halt, then run clears the flag
      tbl.push_back(v(1, 4'b0000, 0, 4'hF, 8'hFF, 0, 1, 1, 1));
      tbl.push_back(v(1, 4'b0000, 0, 4'hF, 8'hFF, 0, 1, 1, 1));
      tbl.push_back(v(1, 4'b0010, 0, 4'h0, 8'h01, 0, 1, 2, 0));
      tbl.push_back(v(1, 4'b0010, 0, 4'h0, 8'h01, 1, 1, 2, 0));
      // halt rise in a tick cycle suppresses cpu_ce
      tbl.push_back(v(1, 4'b0110, 0, 4'h0, 8'h01, 0, 1, 1, 0));
      tbl.push_back(v(1, 4'b0100, 0, 4'h0, 8'h01, 0, 1, 1, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 1, 1, 0));
      // simultaneous run+halt in HALT stays in HALT
      tbl.push_back(v(1, 4'b0110, 0, 4'h0, 8'h01, 0, 1, 1, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 1, 1, 0));
      // CPU reset in the middle of RUN
      tbl.push_back(v(1, 4'b0010, 0, 4'h0, 8'h01, 0, 1, 2, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 1, 1, 2, 0));
      tbl.push_back(v(1, 4'b1000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b1000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b1000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 0, 0, 0));
      tbl.push_back(v(1, 4'b0000, 0, 4'h0, 8'h01, 0, 1, 1, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         set_in(tbl[i].rn, tbl[i].btn, tbl[i].rate, tbl[i].addr, tbl[i].dout);
         apply();
         check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
      end

      // breakpoint at address 5, entered from HALT
      bp_en = 1'b1; bp_addr = 4'h5;
      set_in(1, 4'b0010, 0, 4'h4, 8'h01); apply();
      check("bp_enter_run", dut_out(), 6'b01_10_00);
      set_in(1, 4'b0000, 0, 4'h4, 8'h01); apply();
      check("bp_addr4_ce", dut_out(), 6'b11_10_00);
`ifdef TD4_BREAKPOINT_EN
      set_in(1, 4'b0000, 0, 4'h5, 8'h01); apply();
      check("bp_hit_halt", dut_out(), 6'b01_01_01);
      set_in(1, 4'b0010, 0, 4'h5, 8'h01); apply();
      check("bp_resume_run", dut_out(), 6'b01_10_00);
      set_in(1, 4'b0000, 0, 4'h5, 8'h01); apply();
      check("bp_resume_past", dut_out(), 6'b11_10_00);
`else
      set_in(1, 4'b0000, 0, 4'h5, 8'h01); apply();
      check("bp_ignored", dut_out(), 6'b11_10_00);
`endif
      set_in(1, 4'b0100, 0, 4'h5, 8'h01); apply();
      check("bp_halt_btn", dut_out(), 6'b01_01_00 | {5'b0, dut_out() & 6'b0 });
      bp_en = 1'b0;

      // step then 20 idle cycles with no further pulse
      set_in(1, 4'b0001, 0, 4'h3, 8'h01); apply();
      check("step2_enter", dut_out(), 6'b01_11_00);
      for (int i = 0; i < 21; i++) begin
         set_in(1, 4'b0000, 0, 4'h3, 8'h01); apply();
         exp_v = (i == 0) ? 6'b11_01_00 : 6'b01_01_00;
         check($sformatf("step2_idle[%0d]", i), dut_out(), exp_v);
      end

      // randomized stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         n_reset   = ($urandom_range(0, 299) != 0);
         btn_reset = ($urandom_range(0, 79) == 0);
         btn_halt  = ($urandom_range(0, 11) == 0);
         btn_run   = ($urandom_range(0, 5) == 0);
         btn_step  = ($urandom_range(0, 7) == 0);
         rate_sel  = 2'($urandom_range(0, 1));
         address   = 4'($urandom);
         dout      = ($urandom_range(0, 5) == 0) ? {4'hF, address} : 8'($urandom);
         bp_en     = 1'($urandom);
         bp_addr   = ($urandom_range(0, 2) == 0) ? address : 4'($urandom);
         apply();
         check($sformatf("rand[%0d]", i), dut_out(), model_out());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_td4_run_ctrl
